// File: rtl/branch_trace_sequencer.sv
// Buffers (ip, outcome) branch records, issues them to the predictor
// and scores the returned predictions in saturating counters.
module branch_trace_sequencer #(
  parameter int IP_W       = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IP_W-1:0]  in_ip,
  input  logic             in_taken,
  output logic             pred_ip_valid,
  output logic [IP_W-1:0]  pred_ip,
  output logic             pred_taken,
  input  logic             pred_prediction,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             mispredict_pulse,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IP_W-1:0]       mem_ip_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_tk_q;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic            pred_ip_valid_q, pred_ip_valid_d;
  logic [IP_W-1:0] pred_ip_q, pred_ip_d;
  logic            s1_taken_q, s1_taken_d;
  logic            s1_valid_q, s1_valid_d;
  logic            pred_taken_q, pred_taken_d;
  logic            s2_valid_q, s2_valid_d;

  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;
  logic             mispredict_pulse_q, mispredict_pulse_d;
  logic [CNT_W-1:0] br_base, mis_base;

  logic empty, full, push, pop, mispredict;

  // Extra MSB on the pointers separates full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_valid && !full;
  assign pop   = !empty;

  always_comb begin
    wr_ptr_d        = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d        = rd_ptr_q + (AW+1)'(pop);
    pred_ip_valid_d = pop;
    pred_ip_d       = pred_ip_q;
    s1_taken_d      = s1_taken_q;
    s1_valid_d      = pop;
    if (pop) begin
      pred_ip_d  = mem_ip_q[rd_ptr_q[AW-1:0]];
      s1_taken_d = mem_tk_q[rd_ptr_q[AW-1:0]];
    end
    pred_taken_d = s1_valid_q & s1_taken_q;
    s2_valid_d   = s1_valid_q;
  end

  // A clear coincident with a score restarts counting from that record.
  assign mispredict = (pred_prediction != pred_taken_q);

  always_comb begin
    br_base            = clear_stats ? '0 : branch_count_q;
    mis_base           = clear_stats ? '0 : mispredict_count_q;
    branch_count_d     = br_base;
    mispredict_count_d = mis_base;
    mispredict_pulse_d = 1'b0;
    if (s2_valid_q) begin
      if (br_base != CNT_MAX)
        branch_count_d = br_base + CNT_W'(1);
      if (mispredict) begin
        mispredict_pulse_d = 1'b1;
        if (mis_base != CNT_MAX)
          mispredict_count_d = mis_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ip_q[wr_ptr_q[AW-1:0]] <= in_ip;
      mem_tk_q[wr_ptr_q[AW-1:0]] <= in_taken;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      pred_ip_valid_q    <= 1'b0;
      pred_ip_q          <= '0;
      s1_taken_q         <= 1'b0;
      s1_valid_q         <= 1'b0;
      pred_taken_q       <= 1'b0;
      s2_valid_q         <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      mispredict_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      pred_ip_valid_q    <= pred_ip_valid_d;
      pred_ip_q          <= pred_ip_d;
      s1_taken_q         <= s1_taken_d;
      s1_valid_q         <= s1_valid_d;
      pred_taken_q       <= pred_taken_d;
      s2_valid_q         <= s2_valid_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      mispredict_pulse_q <= mispredict_pulse_d;
    end
  end

  assign in_ready         = !full;
  assign pred_ip_valid    = pred_ip_valid_q;
  assign pred_ip          = pred_ip_q;
  assign pred_taken       = pred_taken_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
  assign mispredict_pulse = mispredict_pulse_q;
  assign busy             = !empty | s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_branch_trace_sequencer.sv
// Randomized bench for branch_trace_sequencer with a queue-based
// reference model and a hash-driven predictor stub.
module tb_branch_trace_sequencer;

  localparam int IP_W  = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IP_W-1:0]  in_ip = '0;
  logic             in_taken = 1'b0;
  logic             pred_ip_valid;
  logic [IP_W-1:0]  pred_ip;
  logic             pred_taken;
  logic             pred_prediction = 1'b0;
  logic             clear_stats = 1'b0;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             mispredict_pulse;
  logic             busy;

  branch_trace_sequencer #(
    .IP_W(IP_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ip(in_ip), .in_taken(in_taken),
    .pred_ip_valid(pred_ip_valid), .pred_ip(pred_ip),
    .pred_taken(pred_taken), .pred_prediction(pred_prediction),
    .clear_stats(clear_stats),
    .branch_count(branch_count),
    .mispredict_count(mispredict_count),
    .mispredict_pulse(mispredict_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Predictor stub: 0 = constant, 1 = parity of the low ip byte.
  logic pmode = 1'b0;
  logic pconst = 1'b0;

  function automatic logic predf(input logic [IP_W-1:0] ip);
    logic [7:0] lo;
    lo = ip[7:0];
    return pmode ? ^lo : pconst;
  endfunction

  always @(posedge clk)
    if (pred_ip_valid) pred_prediction <= predf(pred_ip);

  logic [IP_W-1:0] issued_q[$];
  int pulse_cnt = 0;

  always @(negedge clk) begin
    if (pred_ip_valid === 1'b1) issued_q.push_back(pred_ip);
    if (mispredict_pulse === 1'b1) pulse_cnt++;
  end

  // Reference model state
  logic [IP_W-1:0] exp_ip_q[$];
  logic            exp_tk_q[$];
  int occ = 0;
  int exp_br = 0;
  int exp_mis = 0;
  int exp_pulses = 0;

  function automatic void model_reset_stream();
    exp_ip_q.delete();
    exp_tk_q.delete();
    issued_q.delete();
    pulse_cnt = 0;
    exp_pulses = 0;
  endfunction

  function automatic void apply_model();
    foreach (exp_ip_q[i]) begin
      if (exp_br < CNT_MAX) exp_br++;
      if (exp_tk_q[i] != predf(exp_ip_q[i])) begin
        exp_pulses++;
        if (exp_mis < CNT_MAX) exp_mis++;
      end
    end
  endfunction

  function automatic int issue_errors();
    int e;
    e = 0;
    if (issued_q.size() != exp_ip_q.size()) e++;
    foreach (exp_ip_q[i])
      if (i < issued_q.size() && issued_q[i] !== exp_ip_q[i]) e++;
    return e;
  endfunction

  // Drive one cycle from a negedge, checking in_ready against the model.
  task automatic step(input logic v, input logic [IP_W-1:0] ip,
                      input logic tk);
    logic acc;
    in_valid = v; in_ip = ip; in_taken = tk;
    n_total++;
    if (in_ready !== (occ < DEPTH))
      $display("FAIL in_ready got=%b exp=%b", in_ready, occ < DEPTH);
    else n_pass++;
    acc = v && (occ < DEPTH);
    if (acc) begin
      exp_ip_q.push_back(ip);
      exp_tk_q.push_back(tk);
    end
    occ = occ + int'(acc) - int'(occ > 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic do_clear();
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    exp_br = 0; exp_mis = 0;
    n_total++;
    if (branch_count !== 0 || mispredict_count !== 0)
      $display("FAIL clear got=%0d/%0d exp=0/0",
               branch_count, mispredict_count);
    else n_pass++;
  endtask

  task automatic score_stream(input string nm);
    int e;
    apply_model();
    e = issue_errors();
    n_total++;
    if (e != 0)
      $display("FAIL %s_issue_order got=%0d issued errors=%0d exp=0",
               nm, issued_q.size(), e);
    else n_pass++;
    n_total++;
    if (branch_count !== CNT_W'(exp_br) ||
        mispredict_count !== CNT_W'(exp_mis))
      $display("FAIL %s_counts got=%0d/%0d exp=%0d/%0d", nm,
               branch_count, mispredict_count, exp_br, exp_mis);
    else n_pass++;
    n_total++;
    if (pulse_cnt != exp_pulses)
      $display("FAIL %s_pulses got=%0d exp=%0d", nm,
               pulse_cnt, exp_pulses);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (pred_ip_valid !== 1'b0 || pred_ip !== '0 ||
        pred_taken !== 1'b0 || branch_count !== '0 ||
        mispredict_count !== '0 || mispredict_pulse !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_values got v=%b ip=%0h t=%b bc=%0d mc=%0d p=%b b=%b r=%b exp all 0 r=1",
               pred_ip_valid, pred_ip, pred_taken, branch_count,
               mispredict_count, mispredict_pulse, busy, in_ready);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    occ = 0; exp_br = 0; exp_mis = 0;
    model_reset_stream();
  endtask

  task automatic test_single();
    pmode = 1'b0; pconst = 1'b0;
    model_reset_stream();
    step(1'b1, 64'h40, 1'b1);
    n_total++;
    if (pred_ip_valid !== 1'b0)
      $display("FAIL single_e1 got=%b exp=0", pred_ip_valid);
    else n_pass++;
    idle(1);
    n_total++;
    if (pred_ip_valid !== 1'b1 || pred_ip !== 64'h40 ||
        pred_taken !== 1'b0)
      $display("FAIL single_e2 got v=%b ip=%0h t=%b exp 1/40/0",
               pred_ip_valid, pred_ip, pred_taken);
    else n_pass++;
    idle(1);
    n_total++;
    if (pred_ip_valid !== 1'b0 || pred_taken !== 1'b1 ||
        busy !== 1'b1 || branch_count !== 0)
      $display("FAIL single_e3 got v=%b t=%b b=%b bc=%0d exp 0/1/1/0",
               pred_ip_valid, pred_taken, busy, branch_count);
    else n_pass++;
    idle(1);
    n_total++;
    if (branch_count !== 1 || mispredict_count !== 1 ||
        mispredict_pulse !== 1'b1 || busy !== 1'b0)
      $display("FAIL single_e4 got bc=%0d mc=%0d p=%b b=%b exp 1/1/1/0",
               branch_count, mispredict_count, mispredict_pulse, busy);
    else n_pass++;
    idle(1);
    n_total++;
    if (mispredict_pulse !== 1'b0 || pulse_cnt != 1)
      $display("FAIL single_e5 got p=%b n=%0d exp 0/1",
               mispredict_pulse, pulse_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [IP_W-1:0] ip;
    pmode = 1'b1;
    do_clear();
    model_reset_stream();
    for (int i = 0; i < 10; i++) begin
      ip = {$urandom, $urandom};
      step(1'b1, ip, predf(ip));
    end
    idle(2);
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_busy_p2 got=%b exp=1", busy);
    else n_pass++;
    idle(1);
    n_total++;
    if (busy !== 1'b0) $display("FAIL b2b_busy_p3 got=%b exp=0", busy);
    else n_pass++;
    n_total++;
    if (branch_count !== 10 || mispredict_count !== 0)
      $display("FAIL b2b_fixed got=%0d/%0d exp=10/0",
               branch_count, mispredict_count);
    else n_pass++;
    score_stream("b2b");
  endtask

  task automatic test_wrap();
    pmode = 1'b1;
    do_clear();
    model_reset_stream();
    for (int i = 0; i < 16; i++)
      step(1'b1, IP_W'(i), 1'($urandom));
    idle(4);
    score_stream("wrap");
  endtask

  task automatic test_random_stream();
    pmode = 1'b1;
    do_clear();
    model_reset_stream();
    for (int i = 0; i < 40; i++)
      step(1'($urandom), {$urandom, $urandom}, 1'($urandom));
    idle(4);
    score_stream("random");
  endtask

  task automatic test_saturation();
    pmode = 1'b0; pconst = 1'b0;
    do_clear();
    model_reset_stream();
    for (int i = 0; i < 20; i++)
      step(1'b1, IP_W'(100 + i), 1'b1);
    idle(4);
    score_stream("saturate");
    n_total++;
    if (branch_count !== 15 || mispredict_count !== 15 ||
        pulse_cnt != 20)
      $display("FAIL sat_fixed got=%0d/%0d/%0d exp=15/15/20",
               branch_count, mispredict_count, pulse_cnt);
    else n_pass++;
    step(1'b1, 64'h7, 1'b1);
    idle(2);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    n_total++;
    if (branch_count !== 1 || mispredict_count !== 1 ||
        mispredict_pulse !== 1'b1)
      $display("FAIL clear_coincident got=%0d/%0d p=%b exp=1/1/1",
               branch_count, mispredict_count, mispredict_pulse);
    else n_pass++;
    exp_br = 1; exp_mis = 1;
    idle(2);
  endtask

  task automatic test_reset_midstream();
    pmode = 1'b1;
    model_reset_stream();
    for (int i = 0; i < 5; i++) step(1'b1, IP_W'(200 + i), 1'b0);
    in_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (branch_count !== 0 || mispredict_count !== 0 ||
        pred_ip_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midreset got bc=%0d mc=%0d v=%b b=%b r=%b exp 0/0/0/0/1",
               branch_count, mispredict_count, pred_ip_valid, busy,
               in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b1;
    occ = 0; exp_br = 0; exp_mis = 0;
    model_reset_stream();
    idle(5);
    n_total++;
    if (branch_count !== 0 || mispredict_count !== 0 ||
        issued_q.size() != 0 || pulse_cnt != 0 || busy !== 1'b0)
      $display("FAIL midreset_quiet got bc=%0d mc=%0d iss=%0d p=%0d b=%b exp 0/0/0/0/0",
               branch_count, mispredict_count, issued_q.size(),
               pulse_cnt, busy);
    else n_pass++;
    step(1'b1, 64'h99, 1'b0);
    idle(1);
    n_total++;
    if (pred_ip_valid !== 1'b1 || pred_ip !== 64'h99)
      $display("FAIL midreset_restart got v=%b ip=%0h exp 1/99",
               pred_ip_valid, pred_ip);
    else n_pass++;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_random_stream();
    test_saturation();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
